// File: rtl/ted_timing_pkg.sv
// Shared timing definitions for the TED CPU-timing stage and the raster/DMA request logic.
package ted_timing_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WARN = 2'd1,
      DMA  = 2'd2
   } ted_state_e;

   localparam int CLK_DIV_DEF     = 16;
   localparam int WARN_CYCLES_DEF = 3;
   localparam int LEN_W_DEF       = 7;

endpackage

// File: rtl/cpu_phase_div.sv
// Phase counter and speed latch. cpu_enable is a look-ahead flag: it is high the clock
// before a CPU strobe, so the parent can register the strobe and anything aligned with it.
module cpu_phase_div
   import ted_timing_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic req_fast,
   output logic cpu_enable,
   output logic phase_end
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST     = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] PRE_END  = CW'(CLK_DIV - 2);
   localparam logic [CW-1:0] PRE_HALF = CW'(CLK_DIV / 2 - 2);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          fast_q, fast_d;

   // Speed is only re-sampled on the boundary clock, so a period never gets cut short.
   always_comb begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      fast_d = (cnt_q == LAST) ? req_fast : fast_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         fast_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         fast_q <= fast_d;
      end
   end

   assign phase_end  = (cnt_q == LAST);
   assign cpu_enable = (cnt_q == PRE_END) || (fast_q && (cnt_q == PRE_HALF));

endmodule

// File: rtl/ted_cpu_timing.sv
// CPU bus-timing stage: cycle strobes for the 8501 shell plus the TED DMA handshake
// (RDY warning window, then AEC-low bus ownership for a requested number of slots).
module ted_cpu_timing
   import ted_timing_pkg::*;
#(
   parameter int CLK_DIV     = CLK_DIV_DEF,
   parameter int WARN_CYCLES = WARN_CYCLES_DEF,
   parameter int LEN_W       = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fast_mode,
   input  logic             force_slow,
   input  logic             dma_req,
   input  logic [LEN_W-1:0] dma_len,
   output logic             cpu_enable,
   output logic             rdy,
   output logic             aec,
   output logic             dma_slot,
   output logic             dma_ack,
   output logic             busy
);

   localparam int WW = $clog2(WARN_CYCLES + 1);
   localparam logic [WW-1:0] WARN_LAST = WW'(WARN_CYCLES - 1);

   ted_state_e       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] slot_cnt_q, slot_cnt_d;
   logic [WW-1:0]    warn_cnt_q, warn_cnt_d;
   logic             cpu_enable_q, cpu_enable_d;
   logic             rdy_q, rdy_d;
   logic             aec_q, aec_d;
   logic             dma_slot_q, dma_slot_d;
   logic             dma_ack_q, dma_ack_d;
   logic             busy_q, busy_d;

   logic strobe_next;
   logic boundary;
   logic req_fast;

   // Double speed is only granted while idle; the divider samples this on the boundary clock.
   assign req_fast = boundary & fast_mode & ~force_slow & (state_q == IDLE);

   cpu_phase_div #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_div (
      .clk        (clk),
      .reset      (reset),
      .req_fast   (req_fast),
      .cpu_enable (strobe_next),
      .phase_end  (boundary)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      slot_cnt_d = slot_cnt_q;
      warn_cnt_d = warn_cnt_q;
      dma_ack_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (dma_req && (dma_len != '0)) begin
               state_d    = WARN;
               len_d      = dma_len;
               slot_cnt_d = '0;
               warn_cnt_d = '0;
               dma_ack_d  = 1'b1;
            end
         end
         WARN: begin
            if (cpu_enable_q) begin
               if (warn_cnt_q == WARN_LAST) state_d = DMA;
               else                         warn_cnt_d = warn_cnt_q + 1'b1;
            end
         end
         DMA: begin
            if (dma_slot_q) begin
               if (slot_cnt_q == len_q - 1'b1) state_d = IDLE;
               else                            slot_cnt_d = slot_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs follow the next state so every pin comes straight from a flop.
      cpu_enable_d = strobe_next;
      rdy_d        = (state_d == IDLE);
      aec_d        = (state_d != DMA);
      busy_d       = (state_d != IDLE);
      dma_slot_d   = strobe_next && (state_d == DMA);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         len_q        <= '0;
         slot_cnt_q   <= '0;
         warn_cnt_q   <= '0;
         cpu_enable_q <= 1'b0;
         rdy_q        <= 1'b1;
         aec_q        <= 1'b1;
         dma_slot_q   <= 1'b0;
         dma_ack_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         slot_cnt_q   <= slot_cnt_d;
         warn_cnt_q   <= warn_cnt_d;
         cpu_enable_q <= cpu_enable_d;
         rdy_q        <= rdy_d;
         aec_q        <= aec_d;
         dma_slot_q   <= dma_slot_d;
         dma_ack_q    <= dma_ack_d;
         busy_q       <= busy_d;
      end
   end

   assign cpu_enable = cpu_enable_q;
   assign rdy        = rdy_q;
   assign aec        = aec_q;
   assign dma_slot   = dma_slot_q;
   assign dma_ack    = dma_ack_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_ted_cpu_timing.sv
// Bench for ted_cpu_timing: hand-derived vector table, corner sequences and random traffic,
// all compared every clock against a time/countdown reference model.
module tb_ted_cpu_timing;

   localparam int CLK_DIV     = 16;
   localparam int WARN_CYCLES = 3;
   localparam int LEN_W       = 7;

   logic             clk;
   logic             reset;
   logic             fast_mode;
   logic             force_slow;
   logic             dma_req;
   logic [LEN_W-1:0] dma_len;
   logic             cpu_enable;
   logic             rdy;
   logic             aec;
   logic             dma_slot;
   logic             dma_ack;
   logic             busy;

   int total = 0;
   int bad   = 0;
   int tb_cyc = 0;

   // Reference model: elapsed clocks since reset give the phase; the window is a pair of countdowns.
   int m_cyc;
   bit m_fast;
   bit m_in_warn;
   bit m_in_dma;
   int m_warn_left;
   int m_slots_left;
   bit m_en;
   bit m_ack;

   typedef struct {
      logic             fm;
      logic             fs;
      logic             req;
      logic [LEN_W-1:0] len;
      int               clks;
      logic [5:0]       exp;
   } vec_t;

   vec_t tbl[22];

   ted_cpu_timing #(
      .CLK_DIV     (CLK_DIV),
      .WARN_CYCLES (WARN_CYCLES),
      .LEN_W       (LEN_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fast_mode  (fast_mode),
      .force_slow (force_slow),
      .dma_req    (dma_req),
      .dma_len    (dma_len),
      .cpu_enable (cpu_enable),
      .rdy        (rdy),
      .aec        (aec),
      .dma_slot   (dma_slot),
      .dma_ack    (dma_ack),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] modelVec();
      logic w;
      w = m_in_warn || m_in_dma;
      return {m_en, ~w, ~m_in_dma, m_en & m_in_dma, m_ack, w};
   endfunction

   function automatic void modelStep(input logic rst, input logic fm, input logic fs,
                                     input logic req, input logic [LEN_W-1:0] len);
      bit idle_now;
      bit pulse_now;
      if (rst) begin
         m_cyc = 0; m_fast = 0; m_in_warn = 0; m_in_dma = 0;
         m_warn_left = 0; m_slots_left = 0; m_en = 0; m_ack = 0;
      end else begin
         idle_now  = !m_in_warn && !m_in_dma;
         pulse_now = m_en;
         if (m_cyc % CLK_DIV == CLK_DIV - 1) m_fast = fm && !fs && idle_now;
         m_ack = 0;
         if (idle_now) begin
            if (req && len != 0) begin
               m_in_warn = 1; m_warn_left = WARN_CYCLES; m_slots_left = int'(len); m_ack = 1;
            end
         end else if (m_in_warn) begin
            if (pulse_now) begin
               m_warn_left--;
               if (m_warn_left == 0) begin m_in_warn = 0; m_in_dma = 1; end
            end
         end else if (pulse_now) begin
            m_slots_left--;
            if (m_slots_left == 0) m_in_dma = 0;
         end
         m_cyc++;
         m_en = (m_cyc % CLK_DIV == CLK_DIV - 1) || (m_fast && (m_cyc % CLK_DIV == CLK_DIV / 2 - 1));
      end
   endfunction

   task automatic checkOutput(input string name, input logic [5:0] want);
      logic [5:0] got;
      got = {cpu_enable, rdy, aec, dma_slot, dma_ack, busy};
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %b want %b (en,rdy,aec,slot,ack,busy) cyc=%0d", name, got, want, tb_cyc);
      end
   endtask

   task automatic checkInt(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("[TB] FAIL %s: got %0d want %0d cyc=%0d", name, got, want, tb_cyc);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic fm, input logic fs,
                                input logic req, input logic [LEN_W-1:0] len);
      reset = rst; fast_mode = fm; force_slow = fs; dma_req = req; dma_len = len;
      @(posedge clk);
      modelStep(rst, fm, fs, req, len);
      tb_cyc++;
      #1;
      checkOutput("model", modelVec());
   endtask

   task automatic runWindow(input logic fm, input int budget, output int slots, output int done);
      slots = 0;
      done  = 0;
      for (int i = 0; i < budget; i++) begin
         applyStimulus(1'b0, fm, 1'b0, 1'b0, 7'd0);
         if (dma_slot) slots++;
         if (!busy) begin
            done = 1;
            break;
         end
      end
   endtask

   task automatic waitSlots(input int want, output int seen);
      seen = 0;
      for (int i = 0; i < 400 && seen < want; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
         if (dma_slot) seen++;
      end
   endtask

   initial begin
      int slots;
      int done;
      int seen;
      int last;
      int found;
      int pq[$];
      logic cur_fm;
      logic cur_fs;

      tbl[0]  = '{1'b0, 1'b0, 1'b0, 7'd0, 14, 6'b011000};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 7'd0,  1, 6'b111000};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 7'd0,  1, 6'b011000};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 7'd0, 15, 6'b111000};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 7'd0, 16, 6'b111000};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 7'd0, 16, 6'b111000};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 7'd0,  8, 6'b111000};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 7'd0,  8, 6'b111000};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 7'd0,  4, 6'b011000};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 7'd0,  4, 6'b111000};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 7'd0,  8, 6'b111000};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 7'd0,  8, 6'b011000};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 7'd0,  8, 6'b111000};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 7'd0,  2, 6'b011000};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 7'd5,  1, 6'b001011};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 7'd0,  1, 6'b001001};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 7'd0, 12, 6'b101001};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 7'd0, 32, 6'b101001};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 7'd0,  1, 6'b000001};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 7'd0, 15, 6'b100101};
      tbl[20] = '{1'b0, 1'b0, 1'b0, 7'd0, 64, 6'b100101};
      tbl[21] = '{1'b0, 1'b0, 1'b0, 7'd0,  1, 6'b011000};

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
      checkOutput("reset_state", 6'b011000);

      // Single speed, double speed, force_slow mid-period, then a 5-slot window.
      for (int i = 0; i < 22; i++) begin
         for (int k = 0; k < tbl[i].clks; k++)
            applyStimulus(1'b0, tbl[i].fm, tbl[i].fs, tbl[i].req, tbl[i].len);
         checkOutput($sformatf("row%0d", i), tbl[i].exp);
      end

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
      checkOutput("len0_ignored", 6'b011000);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd2);
      checkOutput("ack_len2", 6'b001011);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd7);
      checkOutput("busy_req_ignored", 6'b001001);
      runWindow(1'b0, 600, slots, done);
      checkInt("len2_done", done, 1);
      checkInt("len2_slots", slots, 2);

      // A request landing on the final slot clock is dropped; the next clock accepts one.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd3);
      checkInt("ack_len3", int'(dma_ack), 1);
      waitSlots(3, seen);
      checkInt("len3_slots_seen", seen, 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd4);
      checkOutput("req_on_last_slot", 6'b011000);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd1);
      checkOutput("ack_after_gap", 6'b001011);
      runWindow(1'b0, 600, slots, done);
      checkInt("len1_slots", slots, 1);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd4);
      waitSlots(2, seen);
      checkInt("len4_slots_before_reset", seen, 2);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
      checkOutput("reset_mid_dma", 6'b011000);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd1);
      checkOutput("ack_after_reset", 6'b001011);
      runWindow(1'b0, 600, slots, done);
      checkInt("post_reset_done", done, 1);
      checkInt("post_reset_slots", slots, 1);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'd127);
      runWindow(1'b0, 2400, slots, done);
      checkInt("max_len_done", done, 1);
      checkInt("max_len_slots", slots, 127);

      // Fast mode requested throughout a window: window runs slow, fast returns after.
      repeat (32) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 7'd3);
      checkInt("ack_fast", int'(dma_ack), 1);
      for (int i = 0; i < 400; i++) begin
         if (!busy) break;
         if (cpu_enable) pq.push_back(tb_cyc);
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
      end
      checkInt("fast_win_pulses", pq.size(), WARN_CYCLES + 3);
      for (int i = 2; i < pq.size(); i++)
         checkInt($sformatf("slow_gap%0d", i), pq[i] - pq[i-1], CLK_DIV);
      last  = -1;
      found = 0;
      for (int i = 0; i < 48; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
         if (cpu_enable) begin
            if (last >= 0 && tb_cyc - last == CLK_DIV / 2) found = 1;
            last = tb_cyc;
         end
      end
      checkInt("fast_resumes", found, 1);

      cur_fm = 1'b1;
      cur_fs = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         logic r;
         logic q;
         logic [LEN_W-1:0] l;
         if ($urandom_range(0, 39) == 0) cur_fm = ~cur_fm;
         if ($urandom_range(0, 59) == 0) cur_fs = ~cur_fs;
         r = ($urandom_range(0, 399) == 0);
         q = !r && ($urandom_range(0, 11) == 0);
         l = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 6));
         applyStimulus(r, cur_fm, cur_fs, q, l);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
